// File: rtl/quad_dec_sample_logger.sv
// ============================================================================
// Module   : quad_dec_sample_logger
// Purpose  : Quadrature decoder with periodic position logging to a ring buffer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_dec_sample_logger #(
  parameter int DEPTH  = 5120,  // must not exceed 2**ADDR_W
  parameter int ADDR_W = 13,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enc_a,
  input  logic              enc_b,
  input  logic              enable,
  input  logic              clear,
  input  logic [DIV_W-1:0]  sample_div,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic [31:0]       position,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              quad_err
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  logic              r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic [1:0]        r_ab_prev;
  logic [31:0]       r_position;
  logic              r_quad_err;
  logic [DIV_W-1:0]  r_timer;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_wrapped;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [31:0]       r_mem_writedata;

  logic [1:0]        w_ab;
  logic [1:0]        w_idx_new;
  logic [1:0]        w_idx_prev;
  logic [1:0]        w_step;
  logic              w_strobe;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [ADDR_W-1:0] w_ptr_next;

  // Gray code 00,01,11,10 maps onto phase index 0..3; the index difference
  // mod 4 gives +1 (1), -1 (3), idle (0) or an illegal double step (2).
  assign w_ab       = {r_a_sync, r_b_sync};
  assign w_idx_new  = {w_ab[1], w_ab[1] ^ w_ab[0]};
  assign w_idx_prev = {r_ab_prev[1], r_ab_prev[1] ^ r_ab_prev[0]};
  assign w_step     = w_idx_new - w_idx_prev;

  assign w_strobe   = enable && (r_timer == '0);

  // The pointer advances at the end of each write cycle; a strobe landing in
  // that same cycle must already target the advanced address.
  assign w_ptr_inc  = (r_wr_ptr == c_last_addr) ? '0 : r_wr_ptr + 1'b1;
  assign w_ptr_next = r_mem_write ? w_ptr_inc : r_wr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_meta  <= 1'b0;
      r_a_sync  <= 1'b0;
      r_b_meta  <= 1'b0;
      r_b_sync  <= 1'b0;
      r_ab_prev <= 2'b00;
    end else begin
      r_a_meta  <= enc_a;
      r_a_sync  <= r_a_meta;
      r_b_meta  <= enc_b;
      r_b_sync  <= r_b_meta;
      r_ab_prev <= w_ab;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_position <= '0;
      r_quad_err <= 1'b0;
    end else if (clear) begin
      r_position <= '0;
      r_quad_err <= 1'b0;
    end else begin
      case (w_step)
        2'd1:    r_position <= r_position + 32'd1;
        2'd3:    r_position <= r_position - 32'd1;
        2'd2:    r_quad_err <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (clear || !enable) begin
      r_timer <= sample_div;
    end else if (r_timer == '0) begin
      r_timer <= sample_div;
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_wr_ptr        <= '0;
      r_wrapped       <= 1'b0;
    end else if (clear) begin
      r_mem_write <= 1'b0;
      r_wr_ptr    <= '0;
      r_wrapped   <= 1'b0;
    end else begin
      r_mem_write <= w_strobe;
      r_wr_ptr    <= w_ptr_next;
      if (w_strobe) begin
        r_mem_address   <= w_ptr_next;
        r_mem_writedata <= r_position;
      end
      if (r_mem_write && (r_wr_ptr == c_last_addr)) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  assign mem_address    = r_mem_address;
  assign mem_chipselect = r_mem_write;
  assign mem_write      = r_mem_write;
  assign mem_byteenable = 4'hF;
  assign mem_writedata  = r_mem_writedata;
  assign mem_clken      = 1'b1;
  assign position       = r_position;
  assign wr_ptr         = r_wr_ptr;
  assign wrapped        = r_wrapped;
  assign quad_err       = r_quad_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_dec_sample_logger.sv
// ============================================================================
// Module   : tb_quad_dec_sample_logger
// Purpose  : Directed self-checking bench for quad_dec_sample_logger (DEPTH=8)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_dec_sample_logger;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 13;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enc_a, enc_b;
  logic              enable, clear;
  logic [DIV_W-1:0]  sample_div;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       position;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wrapped, quad_err;

  int total = 0;
  int bad   = 0;

  quad_dec_sample_logger #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enc_a          (enc_a),
    .enc_b          (enc_b),
    .enable         (enable),
    .clear          (clear),
    .sample_div     (sample_div),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .position       (position),
    .wr_ptr         (wr_ptr),
    .wrapped        (wrapped),
    .quad_err       (quad_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a new A/B level and wait until it has reached position.
  task automatic enc_step(input logic [1:0] ab);
    {enc_a, enc_b} = ab;
    tick();
    tick();
    tick();
  endtask

  task automatic chk_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, 32'(mem_write), 32'd1);
    chk({tag, "_cs"}, 32'(mem_chipselect), 32'd1);
    chk({tag, "_be"}, 32'(mem_byteenable), 32'hF);
    chk({tag, "_addr"}, 32'(mem_address), addr);
    chk({tag, "_data"}, mem_writedata, data);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_we"}, 32'(mem_write), 32'd0);
    chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    enc_a      = 1'b0;
    enc_b      = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    sample_div = 16'd3;

    // Reset held while the encoder toggles
    for (int i = 0; i < 4; i++) begin
      {enc_a, enc_b} = 2'(i + 1);
      tick();
      chk_idle("rst_idle");
      chk("rst_pos", position, 32'd0);
    end
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    chk("rst_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_err", 32'(quad_err), 32'd0);
    chk("rst_be", 32'(mem_byteenable), 32'hF);
    chk("rst_clken", 32'(mem_clken), 32'd1);

    {enc_a, enc_b} = 2'b00;
    tick();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();

    // Single reverse step from zero, then back
    enc_step(2'b10);
    chk("rev_from0", position, 32'hFFFF_FFFF);
    enc_step(2'b00);
    chk("fwd_back0", position, 32'd0);

    // Illegal 00 -> 11
    enc_step(2'b11);
    chk("illegal_err", 32'(quad_err), 32'd1);
    chk("illegal_pos", position, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_err", 32'(quad_err), 32'd0);

    // 8 forward then 3 reverse starting at 11
    enc_step(2'b10); enc_step(2'b00); enc_step(2'b01); enc_step(2'b11);
    enc_step(2'b10); enc_step(2'b00); enc_step(2'b01); enc_step(2'b11);
    chk("fwd8", position, 32'd8);
    enc_step(2'b01); enc_step(2'b00); enc_step(2'b10);
    chk("rev3", position, 32'd5);
    chk("count_err", 32'(quad_err), 32'd0);

    // Sampling with sample_div=3: writes every 4 cycles
    enable = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk_idle("samp_gap");
      end
      tick();
      chk_write("samp_wr", 32'(w), 32'd5);
    end
    enable = 1'b0;
    tick();
    chk_idle("samp_stop");
    chk("samp_ptr", 32'(wr_ptr), 32'd3);

    // Wrap with sample_div=0: 9 back-to-back writes
    clear      = 1'b1;
    sample_div = 16'd0;
    tick();
    clear = 1'b0;
    chk("wrap_clr_ptr", 32'(wr_ptr), 32'd0);
    chk("wrap_clr_pos", position, 32'd0);
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_write("wrap_wr", 32'((k - 1) % DEPTH), 32'd0);
      chk("wrap_ptr", 32'(wr_ptr), 32'((k - 1) % DEPTH));
      chk("wrap_flag", 32'(wrapped), (k == 9) ? 32'd1 : 32'd0);
    end
    enable = 1'b0;
    tick();
    chk_idle("wrap_end");
    chk("wrap_end_ptr", 32'(wr_ptr), 32'd1);
    chk("wrap_end_flag", 32'(wrapped), 32'd1);

    // Clear coincident with a strobe
    enc_step(2'b00);
    chk("pre_clr_pos", position, 32'd1);
    enable = 1'b1;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
    enable = 1'b0;
    chk_idle("clr_strobe");
    chk("clr_strobe_ptr", 32'(wr_ptr), 32'd0);
    chk("clr_strobe_pos", position, 32'd0);
    chk("clr_strobe_wrap", 32'(wrapped), 32'd0);
    tick();
    chk_idle("clr_strobe_after");

    // Enable dropped the cycle after a strobe
    enc_step(2'b01);
    sample_div = 16'd2;
    tick();
    enable = 1'b1;
    tick();
    chk_idle("drop_gap1");
    tick();
    chk_idle("drop_gap2");
    tick();
    chk_write("drop_wr", 32'd0, 32'd1);
    enable     = 1'b0;
    sample_div = 16'd0;
    tick();
    chk_idle("drop_after");
    chk("drop_ptr", 32'(wr_ptr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("drop_quiet");
    end

    // Reset asserted during a write cycle
    enable = 1'b1;
    tick();
    chk("midrst_pre_we", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_write), 32'd0);
    chk("midrst_cs", 32'(mem_chipselect), 32'd0);
    chk("midrst_pos", position, 32'd0);
    chk("midrst_ptr", 32'(wr_ptr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
